// File: rtl/mod_halve_seq.sv
// -----------------------------------------------------------------------------
// mod_halve_seq
//
// Sequential modular halving unit for the field arithmetic layer.
// Computes out = in_a * 2^-k mod CHAR by k exact halvings in GF(p), one
// halving per clock. CHAR (p) is odd. An even residue is halved by a plain
// right shift. An odd residue first has p added, which makes it even, and is
// then shifted.
//
// Operand width and modulus come from the shared field parameters
// (`WORD_SIZE, `CHAR, normally from include/parameter.vh). Fallback values
// below keep this file self-contained when those macros are not predefined.
//
// Optional feature macro:
//   MODHALF_INRED_EN - LOAD performs one conditional subtraction of p, so
//                      any in_a < 2p yields a fully reduced result.
//                      Undefined: no subtractor; in_a must be < p.
//
// Ports:
//   clk    in   1          clock, rising edge
//   rst_n  in   1          asynchronous active-low reset
//   start  in   1          request, honoured only while busy = 0
//   in_a   in   WORD_SIZE  operand, captured with an accepted start
//   in_k   in   SHIFT_W    halving count, captured with an accepted start
//   busy   out  1          high in LOAD and RUN
//   done   out  1          one-cycle pulse in FIN, when out becomes valid
//   out    out  WORD_SIZE  result, held until the next result is produced
// -----------------------------------------------------------------------------

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef CHAR
`define CHAR 65521
`endif

module mod_halve_seq #(
  parameter int SHIFT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [`WORD_SIZE-1:0] in_a,
  input  logic [SHIFT_W-1:0]    in_k,
  output logic                  busy,
  output logic                  done,
  output logic [`WORD_SIZE-1:0] out
);

  localparam int W = `WORD_SIZE;
  // The modulus is held one bit wider so that r + p never overflows.
  localparam logic [W:0] P_EXT = (W+1)'(`CHAR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [W:0]         r_q, r_d;
  logic [SHIFT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]       out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               accept_s;

  // One exact halving step. With r < p the odd-case sum is below 2p, which
  // fits in W+1 bits. The result is again below p, so bit W is clear after
  // the shift.
  function automatic logic [W:0] half_step(input logic [W:0] r);
    logic [W:0] sum;
    if (r[0]) begin
      sum = r + P_EXT;
    end else begin
      sum = r;
    end
    return {1'b0, sum[W:1]};
  endfunction

`ifdef MODHALF_INRED_EN
  // Single conditional subtraction, which brings any value below 2p into [0, p).
  function automatic logic [W:0] cond_sub(input logic [W:0] r);
    if (r >= P_EXT) begin
      return r - P_EXT;
    end else begin
      return r;
    end
  endfunction
`endif

  // A start request is accepted only when the unit is not busy.
  assign accept_s = start && ((state_q == S_IDLE) || (state_q == S_FIN));

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_LOAD;
          r_d     = {1'b0, in_a};
          cnt_d   = in_k;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
`ifdef MODHALF_INRED_EN
        r_d = cond_sub(r_q);
`else
        r_d = r_q;
`endif
        if (cnt_q != {SHIFT_W{1'b0}}) begin
          state_d = S_RUN;
        end else begin
          state_d = S_FIN;
        end
      end

      S_RUN: begin
        r_d   = half_step(r_q);
        cnt_d = cnt_q - SHIFT_W'(1);
        // The last iteration is the one that takes the count from 1 to 0.
        if (cnt_q == SHIFT_W'(1)) begin
          state_d = S_FIN;
        end else begin
          state_d = S_RUN;
        end
      end

      S_FIN: begin
        // Accepting here gives back-to-back operation without an idle cycle.
        if (accept_s) begin
          state_d = S_LOAD;
          r_d     = {1'b0, in_a};
          cnt_d   = in_k;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // FIN never follows itself, so this branch is taken only on entry to FIN.
    if (state_d == S_FIN) begin
      out_d  = r_d[W-1:0];
      done_d = 1'b1;
    end else begin
      out_d  = out_q;
      done_d = 1'b0;
    end

    if ((state_d == S_LOAD) || (state_d == S_RUN)) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // State, datapath and output registers. Reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= {(W+1){1'b0}};
      cnt_q   <= {SHIFT_W{1'b0}};
      out_q   <= {W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule
